// File: rtl/multi_timer.sv
//------------------------------------------------------------------------------
// multi_timer
//
// Bank of NCH down-counting timers behind an 8-bit asynchronous-style CPU bus
// that is sampled on cpuclk. All channels share one prescaler. Each channel
// counts down from its reload value once per prescaler tick and flags an
// expiry in PEND when it ticks at zero. It then reloads (periodic mode) or
// stops (one-shot mode).
//
// Parameters
//   NCH    number of channels (1..4)
//   CNT_W  counter / reload width in bits (8..16)
//   PRESC  cpuclk cycles per count tick (1..256)
//
// Ports
//   cpuclk    clock, rising edge
//   nrst      asynchronous reset, active-low
//   data      8-bit bidirectional CPU data bus
//   ncs       chip select, active-low
//   nwr       write strobe, active-low
//   nrd       read strobe, active-low
//   addr      4-bit register address
//   intr_out  interrupt request, active-high level
//
// Register map (channel c at base 3c)
//   3c+0  W: reload[7:0]        R: live count[7:0]; reading latches count[15:8]
//   3c+1  W: reload[CNT_W-1:8]  R: high byte latched by the last 3c+0 read
//   3c+2  R/W control: bit0 EN, bit1 ONESHOT, bit2 IE
//   12    R: status, bit c = PEND[c]
//   13    W: write-1-to-clear PEND; reads 0x00
//   Anything else (including channels >= NCH) reads 0x00 and ignores writes.
//
// Bus handshake: a write is taken on the first cpuclk edge that sees ncs=0
// and nwr=0, then nothing more is written until the strobe (ncs or nwr)
// goes high again. A read drives data combinationally from addr for as long
// as ncs=0 and nrd=0; the first edge of a read of 3c+0 captures the count
// high byte so a low-then-high read pair is coherent.
//------------------------------------------------------------------------------
module multi_timer #(
    parameter int NCH   = 2,
    parameter int CNT_W = 16,
    parameter int PRESC = 4
) (
    input  logic       cpuclk,
    input  logic       nrst,
    inout  wire  [7:0] data,
    input  logic       ncs,
    input  logic       nwr,
    input  logic       nrd,
    input  logic [3:0] addr,
    output logic       intr_out
);

    // Prescaler is at least one bit wide so PRESC=1 still elaborates.
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    //--------------------------------------------------------------------------
    // Shared prescaler
    //--------------------------------------------------------------------------
    logic [PW-1:0] presc_cnt;
    logic          tick;

    assign tick = (presc_cnt == PW'(PRESC - 1));

    always_ff @(posedge cpuclk or negedge nrst) begin
        if (!nrst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Bus strobe edge detection
    //--------------------------------------------------------------------------
    logic wr_act;
    logic wr_seen;
    logic wr_stb;
    logic rd_act;
    logic rd_seen;
    logic rd_first;

    assign wr_act   = ~ncs & ~nwr;
    assign wr_stb   = wr_act & ~wr_seen;
    assign rd_act   = ~ncs & ~nrd;
    assign rd_first = rd_act & ~rd_seen;

    // wr_seen comes out of reset set: a strobe already low when nrst rises
    // looks like one that was already serviced, so it is ignored until it
    // ends and the detector re-arms.
    always_ff @(posedge cpuclk or negedge nrst) begin
        if (!nrst) begin
            wr_seen <= 1'b1;
            rd_seen <= 1'b0;
        end else begin
            wr_seen <= wr_act;
            rd_seen <= rd_act;
        end
    end

    //--------------------------------------------------------------------------
    // Address decode
    //--------------------------------------------------------------------------
    logic [NCH-1:0] sel_lo;
    logic [NCH-1:0] sel_hi;
    logic [NCH-1:0] sel_ctl;
    logic           sel_stat;
    logic           sel_w1c;

    always_comb begin
        sel_lo  = '0;
        sel_hi  = '0;
        sel_ctl = '0;
        for (int c = 0; c < NCH; c++) begin
            sel_lo[c]  = (addr == 4'(3 * c));
            sel_hi[c]  = (addr == 4'(3 * c + 1));
            sel_ctl[c] = (addr == 4'(3 * c + 2));
        end
        sel_stat = (addr == 4'd12);
        sel_w1c  = (addr == 4'd13);
    end

    //--------------------------------------------------------------------------
    // Channel state
    //--------------------------------------------------------------------------
    logic [CNT_W-1:0] count  [NCH];
    logic [CNT_W-1:0] reload [NCH];
    logic [7:0]       hold   [NCH];
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   oneshot;
    logic [NCH-1:0]   ie;
    logic [NCH-1:0]   pend;

    // 16-bit views of count/reload; bits at or above CNT_W read as zero.
    logic [15:0] cnt16    [NCH];
    logic [15:0] rl16     [NCH];
    logic [15:0] rl_lo16  [NCH];
    logic [15:0] rl_hi16  [NCH];

    logic [NCH-1:0] ctl_wr;
    logic [NCH-1:0] run;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] pend_clr;

    always_comb begin
        ctl_wr = '0;
        run    = '0;
        expire = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt16[c]   = 16'(count[c]);
            rl16[c]    = 16'(reload[c]);
            rl_lo16[c] = {rl16[c][15:8], data};
            rl_hi16[c] = {data, rl16[c][7:0]};
            ctl_wr[c]  = wr_stb & sel_ctl[c];
            // A control write that clears EN takes priority over a tick on
            // the same edge: the channel neither counts nor expires.
            run[c]     = en[c] & tick & ~(ctl_wr[c] & ~data[0]);
            expire[c]  = run[c] & (count[c] == '0);
        end
        pend_clr = (wr_stb & sel_w1c) ? data[NCH-1:0] : '0;
    end

    always_ff @(posedge cpuclk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NCH; c++) begin
                count[c]  <= '0;
                reload[c] <= '0;
                hold[c]   <= '0;
            end
            en      <= '0;
            oneshot <= '0;
            ie      <= '0;
            pend    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                // Reload writes only change the reload register; a running
                // channel picks the new value up at its next reload.
                if (wr_stb && sel_lo[c]) begin
                    reload[c] <= rl_lo16[c][CNT_W-1:0];
                end
                if (wr_stb && sel_hi[c]) begin
                    reload[c] <= rl_hi16[c][CNT_W-1:0];
                end

                if (rd_first && sel_lo[c]) begin
                    hold[c] <= cnt16[c][15:8];
                end

                if (ctl_wr[c]) begin
                    en[c]      <= data[0];
                    oneshot[c] <= data[1];
                    ie[c]      <= data[2];
                end

                if (ctl_wr[c] && data[0] && !en[c]) begin
                    // EN rising: start a fresh period.
                    count[c] <= reload[c];
                end else if (run[c]) begin
                    if (count[c] != '0) begin
                        count[c] <= count[c] - CNT_W'(1);
                    end else if (!oneshot[c]) begin
                        count[c] <= reload[c];
                    end
                end

                // One-shot expiry stops the channel; count stays at zero.
                if (expire[c] && oneshot[c]) begin
                    en[c] <= 1'b0;
                end
            end
            // Set wins over a same-edge clear.
            pend <= (pend & ~pend_clr) | expire;
        end
    end

    //--------------------------------------------------------------------------
    // Interrupt: derived from registered state only
    //--------------------------------------------------------------------------
    assign intr_out = |(pend & ie);

    //--------------------------------------------------------------------------
    // Read mux and bus driver
    //--------------------------------------------------------------------------
    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        for (int c = 0; c < NCH; c++) begin
            if (sel_lo[c]) begin
                rd_data = cnt16[c][7:0];
            end
            if (sel_hi[c]) begin
                rd_data = hold[c];
            end
            if (sel_ctl[c]) begin
                rd_data = {5'b00000, ie[c], oneshot[c], en[c]};
            end
        end
        if (sel_stat) begin
            rd_data = 8'(pend);
        end
    end

    // Bus stays released while reset is asserted.
    assign data = (nrst && !ncs && !nrd) ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  typedef struct {
    logic       is_wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  logic       cpuclk;
  logic       nrst;
  logic       ncs;
  logic       nwr;
  logic       nrd;
  logic [3:0] addr;
  logic       intr_out;
  logic [7:0] tb_data;
  logic       tb_drive;
  wire  [7:0] data_bus;

  int vec_cnt;
  int miscompares;
  int tb_cyc;

  vec_t tbl[$];

  assign data_bus = tb_drive ? tb_data : 8'bzzzz_zzzz;

  multi_timer #(.NCH(2), .CNT_W(16), .PRESC(4)) dut (
    .cpuclk   (cpuclk),
    .nrst     (nrst),
    .data     (data_bus),
    .ncs      (ncs),
    .nwr      (nwr),
    .nrd      (nrd),
    .addr     (addr),
    .intr_out (intr_out)
  );

  // clock / reset
  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  // cpuclk edges since reset release; tick edges are multiples of 4
  always @(posedge cpuclk or negedge nrst) begin
    if (!nrst) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation still running at 1ms, required finish");
    $fatal(1);
  end

  // checks
  task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h required 0x%02h", nm, got, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    vec_cnt++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, got, lo, hi);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge cpuclk);
    nrst = 1'b0;
    repeat (2) @(negedge cpuclk);
    nrst = 1'b1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge cpuclk);
    addr = a; tb_data = d; tb_drive = 1'b1; ncs = 1'b0; nwr = 1'b0;
    @(negedge cpuclk);
    ncs = 1'b1; nwr = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge cpuclk);
    addr = a; ncs = 1'b0; nrd = 1'b0;
    #1 d = data_bus;
    @(negedge cpuclk);
    ncs = 1'b1; nrd = 1'b1;
  endtask

  // wait (bounded) for intr_out, counting negedges from 'start'
  task automatic wait_intr(input int start, input int limit, output int cyc);
    cyc = start;
    while (!intr_out && cyc < limit) begin
      @(negedge cpuclk);
      cyc++;
    end
  endtask

  task automatic align_tick(input int phase);
    int guard;
    guard = 0;
    do begin
      @(negedge cpuclk);
      guard++;
    end while ((tb_cyc % 4) != phase && guard < 16);
  endtask

  task automatic read_all_zero(input string nm);
    logic [7:0] r;
    for (int i = 0; i < 16; i++) begin
      bus_rd(4'(i), r);
      check8($sformatf("%s addr %0d", nm, i), r, 8'h00);
    end
  endtask

  function automatic void add_vec(input logic w, input logic [3:0] a, input logic [7:0] d,
                                  input logic [7:0] e);
    vec_t v;
    v.is_wr = w; v.a = a; v.d = d; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] r;
    logic [7:0] hi_latched;
    int         cyc;

    vec_cnt = 0; miscompares = 0;
    nrst = 1'b0; ncs = 1'b1; nwr = 1'b1; nrd = 1'b1; addr = 4'd0;
    tb_data = 8'h00; tb_drive = 1'b0;

    // register-access table, applied straight after reset
    for (int i = 0; i < 16; i++) add_vec(1'b0, 4'(i), 8'h00, 8'h00);
    add_vec(1'b1, 4'd0,  8'h34, 8'h00);
    add_vec(1'b1, 4'd1,  8'h12, 8'h00);
    add_vec(1'b0, 4'd0,  8'h00, 8'h00);  // reload write leaves count alone
    add_vec(1'b0, 4'd1,  8'h00, 8'h00);
    add_vec(1'b1, 4'd2,  8'h06, 8'h00);
    add_vec(1'b0, 4'd2,  8'h00, 8'h06);
    add_vec(1'b1, 4'd5,  8'hFE, 8'h00);
    add_vec(1'b0, 4'd5,  8'h00, 8'h06);  // unused control bits read 0
    add_vec(1'b1, 4'd6,  8'hFF, 8'h00);
    add_vec(1'b0, 4'd6,  8'h00, 8'h00);  // channel 2 absent
    add_vec(1'b1, 4'd8,  8'hFF, 8'h00);
    add_vec(1'b0, 4'd8,  8'h00, 8'h00);
    add_vec(1'b1, 4'd12, 8'hFF, 8'h00);
    add_vec(1'b0, 4'd12, 8'h00, 8'h00);  // status is read-only
    add_vec(1'b1, 4'd14, 8'hFF, 8'h00);
    add_vec(1'b0, 4'd14, 8'h00, 8'h00);
    add_vec(1'b0, 4'd13, 8'h00, 8'h00);
    add_vec(1'b1, 4'd2,  8'h00, 8'h00);
    add_vec(1'b0, 4'd2,  8'h00, 8'h00);

    // reset state and register table
    do_reset();
    #1;
    check8("reset intr_out", {7'b0, intr_out}, 8'h00);
    check8("reset data idle Z", {7'b0, (data_bus === 8'bzzzz_zzzz)}, 8'h01);
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        bus_wr(tbl[i].a, tbl[i].d);
      end else begin
        bus_rd(tbl[i].a, r);
        check8($sformatf("vec %0d rd addr %0d", i, tbl[i].a), r, tbl[i].exp);
      end
    end

    // periodic channel 0, reload 9: 10 ticks = 40 cycles per period
    do_reset();
    bus_wr(4'd0, 8'h09);
    bus_wr(4'd1, 8'h00);
    bus_wr(4'd2, 8'h05);
    wait_intr(0, 50, cyc);
    check_rng("ch0 first expiry cycles", cyc, 37, 43);
    bus_wr(4'd13, 8'h01);
    check8("ch0 intr after w1c", {7'b0, intr_out}, 8'h00);
    wait_intr(2, 50, cyc);
    check_rng("ch0 period cycles", cyc, 40, 40);

    // one-shot channel 1, reload 2: one expiry after 3 ticks
    do_reset();
    bus_wr(4'd3, 8'h02);
    bus_wr(4'd4, 8'h00);
    bus_wr(4'd5, 8'h07);
    wait_intr(0, 25, cyc);
    check_rng("ch1 oneshot expiry cycles", cyc, 9, 15);
    bus_rd(4'd12, r);
    check8("ch1 status after expiry", r, 8'h02);
    bus_wr(4'd13, 8'h02);
    repeat (60) @(negedge cpuclk);
    check8("ch1 no second intr", {7'b0, intr_out}, 8'h00);
    bus_rd(4'd12, r);
    check8("ch1 no second pend", r, 8'h00);
    bus_rd(4'd5, r);
    check8("ch1 control after oneshot", r, 8'h06);
    bus_rd(4'd3, r);
    check8("ch1 count lo after oneshot", r, 8'h00);
    bus_rd(4'd4, r);
    check8("ch1 count hi after oneshot", r, 8'h00);

    // W1C on the same edge as an expiry: set wins
    do_reset();
    bus_wr(4'd0, 8'h00);
    bus_wr(4'd1, 8'h00);
    bus_wr(4'd2, 8'h01);            // reload 0: expiry on every tick
    align_tick(2);                  // next bus_wr lands on a tick edge
    bus_wr(4'd13, 8'h01);
    bus_rd(4'd12, r);
    check8("w1c vs expiry same edge", r, 8'h01);
    align_tick(0);                  // next bus_wr lands between ticks
    bus_wr(4'd13, 8'h01);
    bus_rd(4'd12, r);
    check8("w1c between ticks", r, 8'h00);

    // coherent low/high read across a 0x??00 boundary
    do_reset();
    bus_wr(4'd0, 8'h34);
    bus_wr(4'd1, 8'h12);
    bus_wr(4'd2, 8'h01);
    bus_rd(4'd0, r);
    check_rng("coherent lo byte", int'(r), 8'h32, 8'h34);
    repeat (300) @(negedge cpuclk);
    bus_rd(4'd1, hi_latched);
    check8("coherent hi byte", hi_latched, 8'h12);
    bus_rd(4'd0, r);
    bus_rd(4'd1, r);
    check8("fresh hi byte", r, 8'h11);

    // write strobe held 10 cycles is a single write
    do_reset();
    bus_wr(4'd0, 8'hFF);
    bus_wr(4'd1, 8'h00);
    @(negedge cpuclk);
    addr = 4'd2; tb_data = 8'h01; tb_drive = 1'b1; ncs = 1'b0; nwr = 1'b0;
    repeat (10) @(negedge cpuclk);
    ncs = 1'b1; nwr = 1'b1; tb_drive = 1'b0;
    bus_rd(4'd0, r);
    check_rng("held enable count lo", int'(r), 8'hFB, 8'hFD);

    do_reset();
    bus_wr(4'd0, 8'h00);
    bus_wr(4'd2, 8'h01);
    align_tick(0);
    addr = 4'd13; tb_data = 8'h01; tb_drive = 1'b1; ncs = 1'b0; nwr = 1'b0;
    repeat (10) @(negedge cpuclk);
    ncs = 1'b1; nwr = 1'b1; tb_drive = 1'b0;
    bus_rd(4'd12, r);
    check8("held w1c clears once", r, 8'h01);

    // strobe active while reset releases is discarded
    @(negedge cpuclk);
    nrst = 1'b0;
    addr = 4'd2; tb_data = 8'h01; tb_drive = 1'b1; ncs = 1'b0; nwr = 1'b0;
    @(negedge cpuclk);
    nrst = 1'b1;
    repeat (3) @(negedge cpuclk);
    ncs = 1'b1; nwr = 1'b1; tb_drive = 1'b0;
    bus_rd(4'd2, r);
    check8("strobe across reset ignored", r, 8'h00);
    bus_wr(4'd2, 8'h06);
    bus_rd(4'd2, r);
    check8("write after reset strobe", r, 8'h06);

    // reset mid-count
    do_reset();
    bus_wr(4'd0, 8'h03);
    bus_wr(4'd2, 8'h05);
    wait_intr(0, 30, cyc);
    check_rng("pre-reset expiry cycles", cyc, 13, 19);
    #2 nrst = 1'b0;
    #1;
    check8("async reset intr_out", {7'b0, intr_out}, 8'h00);
    @(negedge cpuclk);
    nrst = 1'b1;
    read_all_zero("after mid reset");
    repeat (40) @(negedge cpuclk);
    check8("no intr after mid reset", {7'b0, intr_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
